// File: rtl/fluxo_dados_pkg.sv
// Shared definitions for the game datapath and its control unit:
// default widths, the fixed move sequence and the debug state codes.
package fluxo_dados_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  // Sequence the player must reproduce, one one-hot button per position
  localparam logic [DEF_DATA_W-1:0] ROM_SEQ [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  // Control unit state codes as shown on the debug display
  typedef enum logic [3:0] {
    ST_INICIAL  = 4'h0,
    ST_PREPARA  = 4'h1,
    ST_ESPERA   = 4'h2,
    ST_REGISTRA = 4'h3,
    ST_COMPARA  = 4'h4,
    ST_PROXIMO  = 4'h5,
    ST_ACERTOU  = 4'hA,
    ST_ERROU    = 4'hE
  } estado_dbg_t;

endpackage

// File: rtl/fluxo_dados_edge_detector.sv
// Rising-edge detector: pulso is high for exactly one cycle after sinal rises.
module edge_detector (
  input  logic reset,
  input  logic clock,
  input  logic sinal,
  output logic pulso
);

  logic sinal_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sinal_prev <= 1'b0;
    else       sinal_prev <= sinal;
  end

  // History clears on reset, so a button held through reset still yields a pulse
  assign pulso = sinal & ~sinal_prev;

endmodule

// File: rtl/fluxo_dados.sv
// Game datapath: position counter, sequence ROM, move register, comparator
// and button-press detector feeding status back to the control unit.
module fluxo_dados
  import fluxo_dados_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic [DATA_W-1:0] chaves,
  output logic              fim,
  output logic              igual,
  output logic              jogada,
  output logic              db_tem_jogada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_memoria,
  output logic [DATA_W-1:0] db_jogada
);

  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] registro;
  logic [DATA_W-1:0] palavra;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       contagem <= '0;
    else if (zeraC)  contagem <= '0;
    else if (contaC) contagem <= contagem + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          registro <= '0;
    else if (zeraR)     registro <= '0;
    else if (registraR) registro <= chaves;
  end

  assign palavra = ROM_SEQ[contagem];

  assign fim           = &contagem;
  assign igual         = (registro == palavra);
  assign db_tem_jogada = |chaves;
  assign db_contagem   = contagem;
  assign db_memoria    = palavra;
  assign db_jogada     = registro;

  edge_detector u_detector (
    .reset (reset),
    .clock (clock),
    .sinal (db_tem_jogada),
    .pulso (jogada)
  );

endmodule

// File: tb/tb_fluxo_dados.sv
// Bench for fluxo_dados: table-driven steps plus hand sequences, all checked
// through an expected-value queue against a small reference model.
module tb_fluxo_dados;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zeraC = 1'b0, contaC = 1'b0, zeraR = 1'b0, registraR = 1'b0;
  logic [3:0] chaves = 4'b0000;
  logic       fim, igual, jogada, db_tem_jogada;
  logic [3:0] db_contagem, db_memoria, db_jogada;

  fluxo_dados dut (
    .clock(clock), .reset(reset), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .chaves(chaves),
    .fim(fim), .igual(igual), .jogada(jogada), .db_tem_jogada(db_tem_jogada),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  logic [3:0] rom_ref [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  typedef struct {
    logic [3:0] cnt; logic jog; logic [3:0] dbj; logic igl;
    logic fm; logic [3:0] mem; logic tem;
  } exp_t;

  typedef struct {
    logic zc, cc, zr, rr; logic [3:0] ch;
    logic [3:0] e_cnt; logic e_jog; logic [3:0] e_dbj; logic e_igl;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] m_cnt = 4'd0, m_reg = 4'd0;
  logic       m_prev = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Drive one cycle's inputs, check outputs before the edge, advance the model
  task automatic step(input vec_t v, input bit from_table, input string tag);
    exp_t e, got;
    @(negedge clock);
    zeraC = v.zc; contaC = v.cc; zeraR = v.zr; registraR = v.rr; chaves = v.ch;
    if (from_table) begin
      e.cnt = v.e_cnt; e.jog = v.e_jog; e.dbj = v.e_dbj; e.igl = v.e_igl;
      e.fm = (v.e_cnt == 4'd15); e.mem = rom_ref[v.e_cnt];
    end else begin
      e.cnt = m_cnt; e.jog = (|v.ch) & ~m_prev; e.dbj = m_reg;
      e.igl = (m_reg == rom_ref[m_cnt]); e.fm = (m_cnt == 4'd15); e.mem = rom_ref[m_cnt];
    end
    e.tem = |v.ch;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check({tag, ".contagem"}, db_contagem, got.cnt);
      check({tag, ".jogada"}, {3'b0, jogada}, {3'b0, got.jog});
      check({tag, ".db_jogada"}, db_jogada, got.dbj);
      check({tag, ".igual"}, {3'b0, igual}, {3'b0, got.igl});
      check({tag, ".fim"}, {3'b0, fim}, {3'b0, got.fm});
      check({tag, ".memoria"}, db_memoria, got.mem);
      check({tag, ".tem"}, {3'b0, db_tem_jogada}, {3'b0, got.tem});
    end
    if (v.zc) m_cnt = 4'd0; else if (v.cc) m_cnt = m_cnt + 4'd1;
    if (v.zr) m_reg = 4'd0; else if (v.rr) m_reg = v.ch;
    m_prev = |v.ch;
  endtask

  function automatic vec_t mk(input logic zc, cc, zr, rr, input logic [3:0] ch);
    vec_t v;
    v.zc = zc; v.cc = cc; v.zr = zr; v.rr = rr; v.ch = ch;
    v.e_cnt = '0; v.e_jog = 1'b0; v.e_dbj = '0; v.e_igl = 1'b0;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    //         zc cc zr rr chaves  cnt jog dbj    igual
    tbl[0]  = '{0, 0, 0, 0, 4'b0001, 0, 1, 4'b0000, 0};
    tbl[1]  = '{0, 0, 0, 0, 4'b0001, 0, 0, 4'b0000, 0};
    tbl[2]  = '{0, 0, 0, 1, 4'b0001, 0, 0, 4'b0000, 0};
    tbl[3]  = '{0, 0, 0, 0, 4'b0001, 0, 0, 4'b0001, 1};
    tbl[4]  = '{0, 0, 0, 0, 4'b0001, 0, 0, 4'b0001, 1};
    tbl[5]  = '{0, 0, 0, 0, 4'b0000, 0, 0, 4'b0001, 1};
    tbl[6]  = '{0, 0, 0, 0, 4'b0010, 0, 1, 4'b0001, 1};
    tbl[7]  = '{0, 1, 0, 0, 4'b0010, 0, 0, 4'b0001, 1};
    tbl[8]  = '{0, 1, 0, 0, 4'b0000, 1, 0, 4'b0001, 0};
    tbl[9]  = '{0, 0, 0, 1, 4'b1000, 2, 1, 4'b0001, 0};
    tbl[10] = '{0, 0, 0, 0, 4'b1000, 2, 0, 4'b1000, 0};
    tbl[11] = '{0, 0, 1, 1, 4'b1000, 2, 0, 4'b1000, 0};
    tbl[12] = '{0, 0, 0, 0, 4'b0000, 2, 0, 4'b0000, 0};
    tbl[13] = '{0, 0, 0, 1, 4'b0100, 2, 1, 4'b0000, 0};
    tbl[14] = '{0, 0, 0, 0, 4'b0000, 2, 0, 4'b0100, 1};

    repeat (2) @(posedge clock);
    #1;
    check("rst.contagem", db_contagem, 4'd0);
    check("rst.memoria", db_memoria, 4'b0001);
    check("rst.igual", {3'b0, igual}, 4'd0);
    @(negedge clock) reset = 1'b0;

    // single press, register/compare, release and re-press, priorities
    for (int i = 0; i < 15; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // counting to the last position and wrapping
    step(mk(1, 0, 1, 0, 4'b0000), 1'b0, "clr");
    for (int i = 0; i < 15; i++) step(mk(0, 1, 0, 0, 4'b0000), 1'b0, "cnt");
    step(mk(0, 1, 0, 0, 4'b0000), 1'b0, "at15");
    step(mk(0, 0, 0, 0, 4'b0000), 1'b0, "wrap");
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 0, 4'b0000), 1'b0, "to3");
    step(mk(1, 1, 0, 0, 4'b0000), 1'b0, "prio3");
    step(mk(0, 0, 0, 0, 4'b0000), 1'b0, "zeroed");

    // full correct playthrough
    for (int i = 0; i < 16; i++) begin
      step(mk(0, 0, 0, 1, rom_ref[i]), 1'b0, $sformatf("seq%0d.reg", i));
      step(mk(0, 1, 0, 0, rom_ref[i]), 1'b0, $sformatf("seq%0d.cmp", i));
      step(mk(0, 0, 0, 0, 4'b0000), 1'b0, $sformatf("seq%0d.rel", i));
    end

    // two buttons at once
    step(mk(1, 0, 1, 0, 4'b0000), 1'b0, "multi.clr");
    step(mk(0, 0, 0, 1, 4'b0011), 1'b0, "multi.press");
    for (int i = 0; i < 16; i++) step(mk(0, 1, 0, 0, 4'b0011), 1'b0, "multi.cmp");

    // async reset mid-operation: count 5, register 0100
    step(mk(1, 0, 0, 1, 4'b0100), 1'b0, "mid.load");
    for (int i = 0; i < 5; i++) step(mk(0, 1, 0, 0, 4'b0000), 1'b0, "mid.cnt");
    step(mk(0, 0, 0, 0, 4'b0000), 1'b0, "mid.pre");
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async.contagem", db_contagem, 4'd0);
    check("async.db_jogada", db_jogada, 4'd0);
    check("async.memoria", db_memoria, 4'b0001);
    check("async.fim", {3'b0, fim}, 4'd0);
    check("async.jogada", {3'b0, jogada}, 4'd0);
    m_cnt = 4'd0; m_reg = 4'd0; m_prev = 1'b0;

    // button held through reset release
    chaves = 4'b0001;
    @(negedge clock) reset = 1'b0;
    #1;
    check("held.jogada", {3'b0, jogada}, 4'd1);
    m_prev = 1'b1;
    step(mk(0, 0, 0, 0, 4'b0001), 1'b0, "held.after");
    step(mk(0, 0, 0, 0, 4'b0000), 1'b0, "held.rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
